// File: rtl/int_request_ctrl_if.sv
// Interrupt request bus between board-side sources, the PC and int_request_ctrl.
// Optional macro: INT_MASK_EN adds the int_mask request-gating input.
//   irq_src     : raw asynchronous request lines (bit0 = level1)
//   int_running : interruptN_running acknowledge from the PC
//   int_done    : interruptN_done one-cycle retire pulse from decode
//   interrupt   : level-held request lines to the PC
//   pending     : latched, not-yet-acknowledged requests
//   in_service  : acknowledged, not-yet-retired levels
//   lost_cnt    : saturating count of requests dropped while already pending
//   int_mask    : (INT_MASK_EN only) 1 = request line held off for that level
interface int_request_ctrl_if #(
  parameter int unsigned LOST_CNT_W = 8
);
  logic [2:0]            irq_src;
  logic [2:0]            int_running;
  logic [2:0]            int_done;
  logic [2:0]            interrupt;
  logic [2:0]            pending;
  logic [2:0]            in_service;
  logic [LOST_CNT_W-1:0] lost_cnt;
`ifdef INT_MASK_EN
  logic [2:0]            int_mask;
`endif

  // Controller side.
  modport master (
`ifdef INT_MASK_EN
    input  int_mask,
`endif
    input  irq_src,
    input  int_running,
    input  int_done,
    output interrupt,
    output pending,
    output in_service,
    output lost_cnt
  );

  // Board / PC side.
  modport slave (
`ifdef INT_MASK_EN
    output int_mask,
`endif
    output irq_src,
    output int_running,
    output int_done,
    input  interrupt,
    input  pending,
    input  in_service,
    input  lost_cnt
  );
endinterface

// File: rtl/int_request_ctrl.sv
// Three-level interrupt request initiator: conditions raw sources (sync,
// debounce, rising edge), latches pending requests, and drives priority-gated
// interrupt lines until the PC acknowledges via int_running / int_done.
// Level 3 is highest priority. Optional macro: INT_MASK_EN (per-level mask).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : int_request_ctrl_if.master (irq_src, int_running, int_done in;
//           interrupt, pending, in_service, lost_cnt out)
module int_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOST_CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  int_request_ctrl_if.master bus
);

  localparam int unsigned NLVL  = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = LOST_CNT_W + 2;

  logic [NLVL-1:0]       sync1;
  logic [NLVL-1:0]       sync2;
  logic [NLVL-1:0]       level;
  logic [NLVL-1:0]       level_d;
  logic [NLVL-1:0]       run_d;
  logic [CNT_W-1:0]      db_cnt [NLVL];
  logic [NLVL-1:0]       pending_q;
  logic [NLVL-1:0]       in_service_q;
  logic [NLVL-1:0]       interrupt_q;
  logic [LOST_CNT_W-1:0] lost_q;

  logic [NLVL-1:0]       rise_c;
  logic [NLVL-1:0]       ack_c;
  logic [NLVL-1:0]       lost_c;
  logic [NLVL-1:0]       gate_c;
  logic [NLVL-1:0]       mask_c;
  logic [SUM_W-1:0]      lost_sum_c;

`ifdef INT_MASK_EN
  assign mask_c = bus.int_mask;
`else
  assign mask_c = '0;
`endif

  // Two-flop synchroniser for the asynchronous sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.irq_src;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive samples that disagree with the accepted level;
  // any sample agreeing with the level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int k = 0; k < NLVL; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NLVL; k++) begin
        if (sync2[k] == level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level[k]  <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign rise_c = level & ~level_d;
  // The PC acknowledges on the first cycle int_running is seen high.
  assign ack_c  = bus.int_running & ~run_d;
  // A new edge is only lost if the previous request survives this cycle.
  assign lost_c = rise_c & pending_q & ~ack_c;
  // A level may request unless it or any higher level is in service.
  assign gate_c = {~in_service_q[2], ~(|in_service_q[2:1]), ~(|in_service_q)};

  assign lost_sum_c = SUM_W'(lost_q) + SUM_W'(lost_c[0]) + SUM_W'(lost_c[1])
                    + SUM_W'(lost_c[2]);

  // Request / service bookkeeping and registered request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d      <= '0;
      run_d        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      interrupt_q  <= '0;
      lost_q       <= '0;
    end else begin
      level_d      <= level;
      run_d        <= bus.int_running;
      pending_q    <= rise_c | (pending_q & ~ack_c);
      in_service_q <= (in_service_q & ~bus.int_done) | ack_c;
      interrupt_q  <= pending_q & gate_c & ~mask_c;
      if (|lost_sum_c[SUM_W-1:LOST_CNT_W]) begin
        lost_q <= '1;
      end else begin
        lost_q <= lost_sum_c[LOST_CNT_W-1:0];
      end
    end
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.lost_cnt   = lost_q;

endmodule
